// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: UART register map and sequencer state encoding shared by the TX scheduler.
package uart_tx_sched_pkg;
  localparam logic [3:0] STATUS_OFF  = 4'h4;
  localparam logic [3:0] TXDATA_OFF  = 4'hC;
  localparam int         TX_BUSY_BIT = 0;
  typedef enum logic [1:0] {IDLE, POLL, WRITE, DONE} state_t;
endpackage

// File: rtl/uart_tx_sched_msg_buf.sv
// msg_buf: DEPTHx8 message store, one synchronous write port and one asynchronous read port.
module msg_buf #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [7:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: streams a buffered message to the UART TX register, sharing the UART bus
// with the core and forcing the bus after STARVE_MAX consecutive denied cycles.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter  int          DEPTH      = 16,
  parameter  logic [31:0] UART_BASE  = 32'h3000_0000,
  parameter  int          STARVE_MAX = 8,
  localparam int          AW         = $clog2(DEPTH),
  localparam int          LW         = AW + 1,
  localparam int          SW         = $clog2(STARVE_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_idx_i,
  input  logic [7:0]    wr_data_i,
  input  logic [LW-1:0] len_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          core_req_i,
  input  logic          core_we_i,
  input  logic [31:0]   core_addr_i,
  input  logic [31:0]   core_wdata_i,
  input  logic [31:0]   m_rdata_i,
  output logic          m_req_o,
  output logic          m_we_o,
  output logic [31:0]   m_addr_o,
  output logic [31:0]   m_wdata_o,
  output logic          hold_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [LW-1:0] cnt_o
);
  state_t        r_state, w_next;
  logic [LW-1:0] r_len, r_cnt;
  logic [SW-1:0] r_stall;
  logic [7:0]    w_byte;
  logic          w_ctrl, w_core, w_go, w_wr, w_unused;

  assign w_ctrl   = r_state == POLL || r_state == WRITE;
  assign hold_o   = w_ctrl && r_stall == SW'(STARVE_MAX);
  assign w_core   = core_req_i && !hold_o;
  assign w_go     = w_ctrl && !w_core && !abort_i;
  assign w_wr     = w_go && r_state == WRITE;
  assign busy_o   = r_state != IDLE;
  assign done_o   = r_state == DONE;
  assign cnt_o    = r_cnt;
  assign w_unused = ^m_rdata_i;

  // idx always equals the low bits of the byte count, so one counter serves both
  msg_buf #(.DEPTH(DEPTH)) u_buf (
    .clk    (clk),
    .i_we   (wr_en_i && !busy_o),
    .i_waddr(wr_idx_i),
    .i_wdata(wr_data_i),
    .i_raddr(r_cnt[AW-1:0]),
    .o_rdata(w_byte)
  );

  assign m_req_o   = w_core || w_go;
  assign m_we_o    = w_core ? core_we_i : w_wr;
  assign m_addr_o  = w_core ? core_addr_i :
                     !w_go  ? '0 : UART_BASE + {28'b0, r_state == WRITE ? TXDATA_OFF : STATUS_OFF};
  assign m_wdata_o = w_core ? core_wdata_i : w_wr ? {24'b0, w_byte} : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (start_i) w_next = len_i == '0 ? DONE : POLL;
      POLL:        w_next = abort_i ? IDLE : !w_go ? POLL : m_rdata_i[TX_BUSY_BIT] ? POLL : WRITE;
      WRITE:       w_next = abort_i ? IDLE : !w_go ? WRITE : r_cnt + 1'b1 == r_len ? DONE : POLL;
      default:     w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_stall <= w_ctrl && w_core && !abort_i ? r_stall + 1'b1 : '0;
      if (r_state == IDLE && start_i) begin
        r_len <= len_i > LW'(DEPTH) ? LW'(DEPTH) : len_i;
        r_cnt <= '0;
      end else if (w_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: randomized messages, UART busy patterns and core contention checked
// against a transaction-level model of the expected bus traffic.
module tb_uart_tx_sched;
  localparam int          DEPTH      = 16;
  localparam int          AW         = $clog2(DEPTH);
  localparam int          LW         = AW + 1;
  localparam int          STARVE_MAX = 8;
  localparam logic [31:0] BASE       = 32'h3000_0000;

  logic          clk = 0, rst = 0;
  logic          wr_en_i = 0, start_i = 0, abort_i = 0;
  logic [AW-1:0] wr_idx_i = '0;
  logic [7:0]    wr_data_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          core_req_i = 0, core_we_i = 0;
  logic [31:0]   core_addr_i = '0, core_wdata_i = '0, m_rdata_i = '0;
  logic          m_req_o, m_we_o, hold_o, busy_o, done_o;
  logic [31:0]   m_addr_o, m_wdata_o;
  logic [LW-1:0] cnt_o;

  uart_tx_sched #(.DEPTH(DEPTH), .UART_BASE(BASE), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .len_i(len_i), .start_i(start_i), .abort_i(abort_i), .core_req_i(core_req_i),
    .core_we_i(core_we_i), .core_addr_i(core_addr_i), .core_wdata_i(core_wdata_i),
    .m_rdata_i(m_rdata_i), .m_req_o(m_req_o), .m_we_o(m_we_o), .m_addr_o(m_addr_o),
    .m_wdata_o(m_wdata_o), .hold_o(hold_o), .busy_o(busy_o), .done_o(done_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  int         vec, errs, cyc;
  bit         active, want_write, done_next, aborted;
  int         run, polls, writes, lc_cur, busy_left, hold_cnt, done_cyc, t_start;
  logic [7:0] mbuf [DEPTH];
  int         b_q[$];
  logic [7:0] got_q[$];
  int         got_c[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Model of one cycle: who should own the bus, and what the controller should issue
  task automatic observe();
    bit eh, core;
    eh   = active && run == STARVE_MAX;
    core = core_req_i && !eh;
    check("hold", hold_o, eh);
    check("done", done_o, done_next);
    check("busy", busy_o, active || done_next);
    if (done_next) done_cyc = cyc;
    done_next = 0;
    if (eh) hold_cnt++;
    if (core) begin
      check("core_req", m_req_o, 1);
      check("core_we", m_we_o, core_we_i);
      check("core_addr", m_addr_o, core_addr_i);
      check("core_wdata", m_wdata_o, core_wdata_i);
      if (active) run++;
    end else if (active && abort_i) begin
      check("abort_req", m_req_o, 0);
    end else if (active) begin
      run = 0;
      check("ctl_req", m_req_o, 1);
      check("ctl_we", m_we_o, want_write);
      if (want_write) begin
        check("tx_addr", m_addr_o, BASE + 32'hC);
        check("tx_hi", m_wdata_o[31:8], 0);
        got_q.push_back(m_wdata_o[7:0]);
        got_c.push_back(cyc);
        writes++;
        want_write = 0;
        if (writes == lc_cur) begin
          active    = 0;
          done_next = 1;
        end else busy_left = b_q.pop_front();
      end else begin
        check("poll_addr", m_addr_o, BASE + 32'h4);
        polls++;
        if (busy_left > 0) busy_left--;
        else want_write = 1;
      end
    end else begin
      check("idle_req", m_req_o, 0);
    end
    if (active && abort_i) begin
      active  = 0;
      aborted = 1;
    end
  endtask

  task automatic step();
    m_rdata_i = ($urandom() & 32'hFFFF_FFFE) | 32'(busy_left > 0);
    #3;
    observe();
    @(negedge clk);
    cyc++;
  endtask

  task automatic load(input int idx, input logic [7:0] d);
    wr_en_i   = 1;
    wr_idx_i  = AW'(idx);
    wr_data_i = d;
    mbuf[idx] = d;
    step();
    wr_en_i = 0;
  endtask

  // mode 0: no core traffic, 1: random core traffic, 2: core requests every cycle
  task automatic run_msg(input int len, input int mode, input int bmax, input int busy0, input int abort_poll);
    int lc, b, ec, exp_c;
    int b_all[$];
    lc = len > DEPTH ? DEPTH : len;
    for (int i = 0; i < lc; i++) begin
      b = (i == 0 && busy0 >= 0) ? busy0 : int'($urandom_range(0, bmax));
      b_all.push_back(b);
    end
    b_q = b_all;
    busy_left = 0;
    if (lc > 0) busy_left = b_q.pop_front();
    got_q = {}; got_c = {};
    hold_cnt = 0; polls = 0; writes = 0; aborted = 0; run = 0; want_write = 0; done_cyc = -1;
    core_req_i = 0; wr_en_i = 0; abort_i = 0;
    start_i = 1;
    len_i   = LW'(len);
    t_start = cyc;
    step();
    start_i   = 0;
    lc_cur    = lc;
    active    = lc != 0;
    done_next = lc == 0;
    for (int k = 0; k < 2000 && (active || done_next); k++) begin
      core_req_i   = mode == 2 || (mode == 1 && $urandom_range(0, 3) != 0);
      core_we_i    = 1'($urandom());
      core_addr_i  = $urandom();
      core_wdata_i = $urandom();
      wr_en_i      = active && $urandom_range(0, 3) == 0;
      wr_idx_i     = AW'($urandom());
      wr_data_i    = 8'($urandom());
      abort_i      = abort_poll != 0 && active && !want_write && polls == abort_poll - 1;
      step();
    end
    check("timeout", {active, done_next}, 0);
    core_req_i = 0; wr_en_i = 0; abort_i = 0;
    step();
    exp_c = aborted ? writes : lc;
    check("cnt", cnt_o, exp_c);
    check("nbytes", got_q.size(), exp_c);
    ec = t_start;
    for (int i = 0; i < got_q.size() && i < exp_c; i++) begin
      check($sformatf("byte%0d", i), got_q[i], mbuf[i]);
      ec += b_all[i] + 2;
      if (mode == 0) check($sformatf("wr_cyc%0d", i), got_c[i], ec);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    #3;
    check("rst_req", m_req_o, 0);
    check("rst_we", m_we_o, 0);
    check("rst_addr", m_addr_o, 0);
    check("rst_hold", hold_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_cnt", cnt_o, 0);
    @(negedge clk);
    rst = 1;
    cyc = 0;
    for (int i = 0; i < DEPTH; i++) load(i, 8'($urandom()));
    load(0, 8'h32); load(1, 8'h30); load(2, 8'h32); load(3, 8'h33);

    run_msg(4, 0, 0, 0, 0);
    check("msg2023_done", done_cyc, t_start + 9);

    run_msg(4, 0, 0, 5, 0);
    check("busy5_done", done_cyc, t_start + 14);

    run_msg(2, 2, 0, 0, 0);
    check("starve_done", done_cyc, t_start + 37);
    check("starve_holds", hold_cnt, 4);

    run_msg(0, 0, 0, 0, 0);
    check("len0_done", done_cyc, t_start + 1);

    run_msg(5, 0, 0, 0, 3);
    check("abort_cnt", cnt_o, 2);
    check("abort_done", done_cyc, -1);

    // asynchronous reset in the middle of a WRITE cycle
    start_i = 1; len_i = LW'(3);
    step();
    start_i = 0;
    active = 1; lc_cur = 3; want_write = 0; busy_left = 0; done_next = 0; run = 0;
    b_q = {0, 0}; writes = 0; polls = 0;
    step();
    #2;
    check("pre_rst_we", m_we_o, 1);
    rst = 0;
    #1;
    check("arst_req", m_req_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_done", done_o, 0);
    check("arst_cnt", cnt_o, 0);
    @(negedge clk);
    cyc++;
    rst = 1;
    active = 0; done_next = 0;
    run_msg(2, 0, 0, 0, 0);

    for (int m = 0; m < 24; m++) begin
      for (int j = int'($urandom_range(0, 6)); j > 0; j--) load(int'($urandom_range(0, DEPTH - 1)), 8'($urandom()));
      run_msg(int'($urandom_range(0, 2 * DEPTH - 1)), int'($urandom_range(0, 1)), 3, -1, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Hardware sequencer that streams a loaded byte message out through the memory-mapped UART without software polling. It sits between the execute stage and the UART slave port and owns the UART bus mux. It polls the UART status register, writes each byte to the TX data register, and shares the bus with core accesses using a starvation guard.

## Interface
Parameters:
- DEPTH, 16: message buffer entries (power of two).
- UART_BASE, 32'h3000_0000: UART base address.
- STARVE_MAX, 8: consecutive denied cycles before the controller forces the bus.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-low.
- wr_en_i, in, 1: buffer write strobe from ex.
- wr_idx_i, in, log2(DEPTH): buffer write index.
- wr_data_i, in, 8: buffer write byte.
- len_i, in, log2(DEPTH)+1: message length, sampled on start.
- start_i, in, 1: start pulse.
- abort_i, in, 1: abort transmission.
- core_req_i, in, 1: core requests UART bus.
- core_we_i, in, 1: core write enable.
- core_addr_i, in, 32: core address.
- core_wdata_i, in, 32: core write data.
- m_rdata_i, in, 32: UART read data, combinational in the request cycle.
- m_req_o, out, 1: UART bus request.
- m_we_o, out, 1: UART bus write enable.
- m_addr_o, out, 32: UART bus address.
- m_wdata_o, out, 32: UART bus write data.
- hold_o, out, 1: stall the core, asserted only while the controller is forcing the bus.
- busy_o, out, 1: message in progress.
- done_o, out, 1: one-cycle pulse on normal completion.
- cnt_o, out, log2(DEPTH)+1: bytes written so far.

## Operation
- States:
  - IDLE: buffer writable; waits for start.
  - POLL: read UART_BASE+4.
  - WRITE: write UART_BASE+0xC.
  - DONE: one cycle; done_o=1.
- IDLE to POLL on start_i with len_i!=0. The length is latched and clamped to DEPTH. idx and cnt_o are cleared.
- start_i with len_i==0 goes IDLE to DONE, with no bus traffic.
- start_i while busy is ignored. wr_en_i while busy is ignored; buffer contents are unchanged.
- POLL: if m_rdata_i[0]==1 (TX busy), stay in POLL and re-read next cycle. If it is 0, go to WRITE.
- WRITE: m_wdata_o={24'b0,buf[idx]}. Then idx and cnt_o increment. If cnt_o+1==len, go to DONE, else go to POLL.
- DONE goes to IDLE.
- abort_i in POLL or WRITE: the cycle's bus transaction is suppressed, then IDLE at the next edge. No done_o; cnt_o is kept.
- Bus mux, per cycle:
  - When hold_o=0 and core_req_i=1, the core fields pass through and the controller FSM stalls (state and idx frozen).
  - Otherwise the controller drives the bus when in POLL or WRITE, and m_req_o=0 elsewhere.
- Starvation guard:
  - A stall counter increments on each POLL/WRITE cycle denied by core_req_i.
  - When it reaches STARVE_MAX, hold_o=1 on the next cycle. The controller owns the bus that cycle and the core request is ignored; the core must hold its request.
  - The counter clears on any controller transaction, and in IDLE.
- Reset: state IDLE; all outputs 0 (core passthrough fields are 0 only when core_req_i=0); cnt_o=0; stall counter 0. Buffer contents are not reset.

## Timing
- start_i sampled at edge t. First POLL read occurs in cycle t+1.
- No contention and UART idle: 2 cycles per byte. Last write in cycle t+2N. done_o=1 and busy_o=1 in cycle t+2N+1. busy_o=0 from t+2N+2.
- busy_o=1 in POLL, WRITE and DONE.
- Bus outputs are combinational from state and core inputs; there is no registered latency on the mux.
- Poll result is sampled on the edge closing the read cycle.
- Buffer write: data visible to a WRITE starting the next cycle after the strobe.
- Async reset mid-message: immediate IDLE, m_req_o=0, no done_o.

## Structure
- Shared package `uart_tx_sched_pkg`:
  - UART register offsets (STATUS=4'h4, TXDATA=4'hC).
  - TX-busy bit index (0).
  - State encoding (2-bit: IDLE, POLL, WRITE, DONE).
- Sub-module `msg_buf`: DEPTH×8 register file with one synchronous write port and one asynchronous read port; no reset.
- Top level holds the FSM, counters, stall counter and the bus mux.

## Test plan
- Load "2023" (8'h32,8'h30,8'h32,8'h33) with len=4 and UART always idle -> writes of 0x32,0x30,0x32,0x33 to 0x3000000C at cycles t+2/4/6/8. done_o is high at t+9. cnt_o=4.
- UART status bit0=1 for 5 reads before the first byte -> 6 POLL reads, then the first write. Total completion is delayed by exactly 5 cycles.
- core_req_i held high throughout a len=2 message with STARVE_MAX=8 -> core passthrough for 8 cycles, then one hold_o=1 cycle carrying a controller transaction. The pattern repeats until done_o.
- start_i with len_i=0 -> done_o pulse at t+1, m_req_o never asserted.
- abort_i during the third POLL of a len=5 message -> no write that cycle, IDLE next cycle, done_o stays 0, cnt_o=2.
- Reset asserted mid-WRITE -> all outputs 0 immediately. A new start after release transmits from index 0.
